// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master                                                      |
// | Purpose  : SPI mode-0 (CPOL=0, CPHA=0) initiator, MSB first. SCLK is       |
// |            CLK divided by 2*CLK_DIV. Host side uses start/busy/done with   |
// |            parallel tx/rx words.                                           |
// | Ports    : CLK      - system clock, rising-edge                            |
// |            RESET    - asynchronous active-high reset                       |
// |            start    - transfer request, sampled only while idle            |
// |            tx_data  - word to send, latched when start is accepted         |
// |            busy     - high from start acceptance through the GAP state     |
// |            done     - one-cycle pulse, rx_data valid in that cycle         |
// |            rx_data  - last received word, held until the next done         |
// |            SCLK     - serial clock, idles low                              |
// |            CS       - chip select, active low                              |
// |            MOSI     - serial data out, changes on SCLK falling edges       |
// |            MISO     - serial data in, sampled on SCLK rising edges         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_master #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rx_data,
   output logic             SCLK,
   output logic             CS,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_bit_w = $clog2(WIDTH + 1);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
   // GAP lasts CLK_DIV-1 cycles; only meaningful when CLK_DIV > 1
   localparam logic [c_div_w-1:0] c_gap_last = c_div_w'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);
   localparam logic [c_bit_w-1:0] c_width    = c_bit_w'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEAD = 3'd1,
      S_HIGH = 3'd2,
      S_LOW  = 3'd3,
      S_DONE = 3'd4,
      S_GAP  = 3'd5
   } state_t;

   state_t             state_q,    state_d;
   logic [c_div_w-1:0] div_q,      div_d;
   logic [c_bit_w-1:0] bit_cnt_q,  bit_cnt_d;
   logic [WIDTH-1:0]   tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0]   rx_data_q,  rx_data_d;
   logic               sclk_q,     sclk_d;
   logic               cs_q,       cs_d;
   logic               mosi_q,     mosi_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;

   logic               w_div_last;

   assign w_div_last = (div_q == c_div_last);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      cs_d       = cs_q;
      mosi_d     = mosi_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            div_d     = '0;
            bit_cnt_d = '0;
            if (start) begin
               tx_shift_d = tx_data;
               mosi_d     = tx_data[WIDTH-1];
               cs_d       = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_LEAD;
            end
         end

         S_LEAD: begin
            if (w_div_last) begin
               div_d      = '0;
               sclk_d     = 1'b1;
               rx_shift_d = {rx_shift_q[WIDTH-2:0], MISO};
               bit_cnt_d  = bit_cnt_q + c_bit_w'(1);
               state_d    = S_HIGH;
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end

         S_HIGH: begin
            if (w_div_last) begin
               div_d  = '0;
               sclk_d = 1'b0;
               // After the last bit MOSI keeps the LSB through the final LOW phase
               if (bit_cnt_q < c_width) begin
                  tx_shift_d = tx_shift_q << 1;
                  mosi_d     = tx_shift_q[WIDTH-2];
               end
               state_d = S_LOW;
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end

         S_LOW: begin
            if (w_div_last) begin
               div_d = '0;
               if (bit_cnt_q < c_width) begin
                  sclk_d     = 1'b1;
                  rx_shift_d = {rx_shift_q[WIDTH-2:0], MISO};
                  bit_cnt_d  = bit_cnt_q + c_bit_w'(1);
                  state_d    = S_HIGH;
               end else begin
                  // Final LOW phase doubles as the trailing CS hold time
                  cs_d      = 1'b1;
                  mosi_d    = 1'b0;
                  rx_data_d = rx_shift_q;
                  done_d    = 1'b1;
                  state_d   = S_DONE;
               end
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end

         S_DONE: begin
            div_d = '0;
            if (CLK_DIV == 1) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            if (div_q == c_gap_last) begin
               div_d   = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign SCLK    = sclk_q;
   assign CS      = cs_q;
   assign MOSI    = mosi_q;

endmodule
`default_nettype wire
